// File: rtl/instr_encoder.sv
// instr_encoder: assembles symbolic RV32I requests (ADDI/XORI/ORI/ANDI,
// ADD/XOR/OR/AND, LW, SW, BNE) into 32-bit machine words and writes them
// sequentially into instruction memory through one write port.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a program load (IDLE only)
//   req_valid/req_ready   request handshake
//   req_op/rd/rs1/rs2/imm symbolic instruction fields
//   req_last              final instruction of the program
//   imem_we/addr/wdata    memory write port, imem_ready accepts the write
//   busy, done, count     load status, done pulses once at completion
//   err                   sticky illegal-op flag
//
// Optional feature: define INSTR_ENCODER_ILLEGAL_FLAG_EN to drop illegal ops
// (11-15) and flag them on err; otherwise they encode as NOP and err is 0.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [12:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_next;
  logic [OCC_W-1:0]  occ, occ_after_pop, occ_next, fill_next;
  logic              enc_valid;
  logic [31:0]       enc_word;
  logic              accept, enc_load, push, pop, room_next;
  logic [31:0]       head_next;

  // Standard RV32I encoding of the supported subset; anything else is NOP.
  function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [12:0] imm);
    logic [2:0] f3;
    case (op[1:0])
      2'd0:    f3 = 3'b000;
      2'd1:    f3 = 3'b100;
      2'd2:    f3 = 3'b110;
      default: f3 = 3'b111;
    endcase
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3: encode = {imm[11:0], rs1, f3, rd, 7'b0010011};
      4'd4, 4'd5, 4'd6, 4'd7: encode = {7'b0, rs2, rs1, f3, rd, 7'b0110011};
      4'd8:    encode = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      4'd9:    encode = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      4'd10:   encode = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
      default: encode = 32'h0000_0013;
    endcase
  endfunction

`ifdef INSTR_ENCODER_ILLEGAL_FLAG_EN
  logic illegal;
  assign illegal = (req_op > 4'd10);
`endif

  // FIFO bookkeeping; the encode register counts toward fullness so that
  // req_ready never admits a word that would not fit.
  always_comb begin
    accept = req_valid & req_ready;
`ifdef INSTR_ENCODER_ILLEGAL_FLAG_EN
    enc_load = accept & ~illegal;
`else
    enc_load = accept;
`endif
    push          = enc_valid;
    pop           = imem_we & imem_ready;
    rd_ptr_next   = rd_ptr + PTR_W'(pop);
    occ_after_pop = occ - OCC_W'(pop);
    occ_next      = occ_after_pop + OCC_W'(push);
    fill_next     = occ_next + OCC_W'(enc_load);
    room_next     = (fill_next < OCC_W'(DEPTH));
    // When the pop empties the FIFO, the incoming word becomes the new head.
    head_next     = (occ_after_pop == '0) ? enc_word : mem[rd_ptr_next];
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  // Encode stage, FIFO pointers and the registered write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_valid  <= 1'b0;
      enc_word   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      imem_we    <= 1'b0;
      imem_wdata <= '0;
      imem_addr  <= ADDR_W'(BASE_ADDR);
      count      <= '0;
    end else begin
      enc_valid <= enc_load;
      if (enc_load) enc_word <= encode(req_op, req_rd, req_rs1, req_rs2, req_imm);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr  <= rd_ptr_next;
      occ     <= occ_next;
      imem_we <= (occ_next != '0);
      if (occ_next != '0) imem_wdata <= head_next;
      if (state == IDLE && start) begin
        imem_addr <= ADDR_W'(BASE_ADDR);
        count     <= '0;
      end else if (pop) begin
        imem_addr <= imem_addr + ADDR_W'(1);
        if (count != COUNT_MAX) count <= count + (ADDR_W+1)'(1);
      end
    end
  end

  // Load-sequencing FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            req_ready <= room_next;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (accept && req_last) begin
            state     <= FLUSH;
            req_ready <= 1'b0;
          end else begin
            req_ready <= room_next;
          end
        end
        FLUSH: begin
          if (occ == '0 && !enc_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
`ifdef INSTR_ENCODER_ILLEGAL_FLAG_EN
      if (state == IDLE && start) err <= 1'b0;
      else if (accept && illegal) err <= 1'b1;
`else
      err <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control decoder: accepts symbolic instruction requests (op, rd, rs1, rs2, imm) and emits 32-bit RV32I machine words.
- Words are written sequentially into instruction memory through a single write port.
- Used by the bench/boot path to assemble programs in-system.
- Covers exactly the decoded subset: ADDI, XORI, ORI, ANDI, ADD, XOR, OR, AND, LW, SW, BNE.

Parameters:
- ADDR_W, 8, imem word-address width.
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 4, encoded-word FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin a program load; honoured only in IDLE.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_op  in  4  0 ADDI, 1 XORI, 2 ORI, 3 ANDI, 4 ADD, 5 XOR, 6 OR, 7 AND, 8 LW, 9 SW, 10 BNE, 11-15 illegal.
- req_rd  in  5  destination register.
- req_rs1  in  5  source 1.
- req_rs2  in  5  source 2.
- req_imm  in  13  signed immediate/offset.
- req_last  in  1  marks final instruction of the program.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded word.
- imem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the load completes.
- count  out  ADDR_W+1  words written since start.
- err  out  1  sticky illegal-op flag (see Optional Feature).

Behaviour:
- Reset values: req_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, count=0, err=0.
- Reset also empties the FIFO and forces IDLE, including mid-operation; pending words are discarded.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: req_ready=0. On start: go to RUN; imem_addr:=BASE_ADDR, count:=0, err:=0.
  - RUN: req_ready = !fifo_full. An accept with req_last=1 moves to FLUSH.
  - FLUSH: req_ready=0. When the FIFO is empty and no write is outstanding, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - start is ignored outside IDLE.
- Encoding is standard RV32I. Encode is registered: an accepted request enters the FIFO at the next edge.
  - I-type (ops 0-3, 8): {imm[11:0], rs1, f3, rd, opcode}. f3 = 000/100/110/111; LW uses f3=010. Opcode 0010011, or 0000011 for LW.
  - R-type (ops 4-7): {7'b0, rs2, rs1, f3, rd, 0110011}, with the same f3 mapping as ops 0-3.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - BNE: {imm[12], imm[10:5], rs2, rs1, 001, imm[4:1], imm[11], 1100011}; imm[0] is ignored.
  - Unused fields (rs2 for I-type, rd for S/B) are ignored.
  - imm[12] is ignored for non-BNE ops.
- Drain: imem_we=1 whenever the FIFO is non-empty; imem_wdata = FIFO head and imem_addr = current address.
  - imem_we & imem_ready pops the FIFO, increments imem_addr and increments count.
  - While imem_ready=0, imem_we, imem_addr and imem_wdata hold stable.
- Minimum latency: request accept to first imem_we is 2 cycles. Sustained throughput is 1 word/cycle.
- FIFO boundaries:
  - Full: req_ready=0; no same-cycle bypass.
  - Push and pop in the same cycle when not full: occupancy unchanged.
  - Empty: imem_we=0.
- Address wraps modulo 2^ADDR_W. count saturates at 2^ADDR_W.

Optional Feature:
- Macro: INSTR_ENCODER_ILLEGAL_FLAG_EN.
- Defined: an illegal op (11-15) is dropped (no FIFO push, count unaffected) and sets err. err stays set until the next start or reset. The request is still handshaken. An illegal op with req_last=1 still moves to FLUSH.
- Undefined: an illegal op encodes as NOP 0x00000013 (ADDI x0,x0,0) and is written normally; err is tied to 0.

Test Plan:
- start; ADDI rd=1 rs1=0 imm=5, last=1; imem_ready=1 -> one write 0x00500093 @BASE_ADDR; done pulses; count=1.
- Sequence ADD rd3 rs1=1 rs2=2 / LW rd5 rs1=1 imm=4 / SW rs1=1 rs2=2 imm=8 / BNE rs1=1 rs2=2 imm=-8 -> writes at addr 0..3:
  - 0x002081B3, 0x0040A283, 0x0020A423, 0xFE209CE3.
- imem_ready=0 for 10 cycles with DEPTH=4 -> req_ready drops after 4 accepts; wdata/addr hold stable; releasing imem_ready drains in order with no loss or duplication.
- BASE_ADDR=254, ADDR_W=8, 4 words -> addresses 254, 255, 0, 1; count=4.
- Illegal op 12 mid-program -> with macro: word skipped, err=1, subsequent addresses contiguous; without macro: 0x00000013 written, err=0.
- rst_n low during FLUSH with 3 words queued -> next cycle: all outputs at reset values, no further imem_we, busy=0.
